// File: rtl/vram_arbiter.sv
// Character RAM arbiter: renderer reads have priority, buffered CPU writes
// and a screen-clear sweep fill the free slots, with a starvation guard.
module vram_arbiter #(
    parameter int                ADDR_W       = 14,
    parameter int                DATA_W       = 8,
    parameter int                FIFO_DEPTH   = 4,
    parameter int                STARVE_LIMIT = 64,
    parameter int                CLEAR_WORDS  = 2400,
    parameter logic [DATA_W-1:0] CLEAR_CHAR   = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              wr_pending,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [PTR_W:0]    FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  LIM      = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              clr_busy_q;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [PTR_W:0]    level_q;
    logic [PTR_W:0]    level_d;

    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;

    logic              rd_gnt_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    logic empty;
    logic full;
    logic sweeping;
    logic wr_avail;
    logic forced;
    logic rd_gnt;
    logic wr_gnt;
    logic push;
    logic pop;

    assign empty    = (level_q == '0);
    assign full     = (level_q == FULL_LVL);
    assign sweeping = (state_q == CLEAR);
    assign wr_avail = sweeping | ~empty;
    assign forced   = (STARVE_LIMIT != 0) && (starve_q == LIM);

    // Grants are suppressed in the reset cycle so nothing reaches the RAM.
    assign rd_gnt = rd_req & ~forced & ~rst;
    assign wr_gnt = ~rd_gnt & wr_avail & ~rst;

    assign cpu_wr_ready = (state_q == IDLE) && !full;
    assign push         = cpu_wr_valid & cpu_wr_ready;
    assign pop          = wr_gnt & ~sweeping;

    assign mem_we    = wr_gnt;
    assign mem_addr  = !wr_gnt ? rd_addr :
                       sweeping ? clr_addr_q : fifo_addr_q[rptr_q];
    assign mem_wdata = sweeping ? CLEAR_CHAR : fifo_data_q[rptr_q];

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign clr_busy   = clr_busy_q;
    assign wr_pending = ~empty;

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (wr_gnt || !wr_avail) begin
            starve_d = '0;
        end else if (rd_req && starve_q != LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clr_start) begin
                        state_q    <= DRAIN;
                        clr_busy_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                    end
                end
                CLEAR: begin
                    if (wr_gnt) begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                        if (clr_addr_q == CLR_LAST) begin
                            state_q    <= IDLE;
                            clr_busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            starve_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            level_q  <= level_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= cpu_wr_addr;
            fifo_data_q[wptr_q] <= cpu_wr_data;
        end
    end

    // Stage 1 tracks the RAM access, stage 2 captures its data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_gnt_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_gnt_q   <= rd_gnt;
            rd_valid_q <= rd_gnt_q;
            if (rd_gnt_q) begin
                rd_data_q <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port character RAM behind the text renderer between two users: the renderer's per-pixel character fetch, and CPU-side writes, plus a built-in screen-clear sweep.
- The renderer has priority, with a fixed read latency.
- CPU writes are buffered in a small FIFO and drained into free memory slots. A starvation guard forces a write slot after a bounded stall.
- Sits between the renderer (read index / ascii path) and the text RAM inside the graphics card.

Parameters:
ADDR_W, 14, character RAM address width (matches renderer read index)
DATA_W, 8, character code width
FIFO_DEPTH, 4, CPU write buffer entries (power of two, >=2)
STARVE_LIMIT, 64, consecutive denied cycles before one write slot is forced; 0 disables forcing
CLEAR_WORDS, 2400, number of words written by a clear sweep (80x30 text)
CLEAR_CHAR, 8'h20, value written by a clear sweep

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rd_req  in  1  renderer requests a read this cycle
rd_addr  in  ADDR_W  renderer read index
rd_data  out  DATA_W  character returned to renderer
rd_valid  out  1  rd_data holds the response to the request two cycles earlier
cpu_wr_valid  in  1  CPU write offered
cpu_wr_ready  out  1  CPU write accepted when valid&ready
cpu_wr_addr  in  ADDR_W  CPU write address
cpu_wr_data  in  DATA_W  CPU write data
clr_start  in  1  pulse: start clear sweep
clr_busy  out  1  clear pending or in progress
wr_pending  out  1  FIFO non-empty
mem_addr  out  ADDR_W  RAM address (combinational from grant)
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after address (synchronous RAM)

Behaviour:
Reset (sync, any state):
- FIFO empty; FSM=IDLE; starve counter=0; clear address=0.
- rd_valid=0, rd_data=0, clr_busy=0, wr_pending=0, mem_we=0.
- cpu_wr_ready=1 the cycle after reset releases.
- A clear in progress is aborted; no partial-sweep resume.

Per-cycle grant:
- Writer source is the clear engine when FSM=CLEAR, else the FIFO head when the FIFO is non-empty.
- Grant goes to the renderer if rd_req=1 and not forced; otherwise to the writer, if any.
- mem_addr/mem_we/mem_wdata are driven combinationally from the granted source in the same cycle.
- With no grant: mem_we=0, mem_addr=rd_addr.

Read path:
- Renderer granted in cycle t -> mem_rdata valid at t+1 -> registered -> rd_data/rd_valid=1 in cycle t+2. Fixed 2-cycle latency.
- Cycles without a renderer grant produce rd_valid=0 two cycles later; rd_data holds its last value.

Starvation guard:
- The counter increments each cycle that rd_req=1 and a writer is waiting; it clears on any writer grant or when no writer is waiting.
- When counter==STARVE_LIMIT (STARVE_LIMIT!=0), the next cycle is forced to the writer and the counter resets to 0.
- The renderer request in that cycle is dropped, giving rd_valid=0 at t+2.

FIFO:
- Push on cpu_wr_valid&cpu_wr_ready; pop on writer grant while FSM!=CLEAR.
- Simultaneous push and pop leaves the level unchanged.
- cpu_wr_ready = (FSM==IDLE) && !full.
- Data is written in arrival order.
- A renderer read of an address still in the FIFO returns the old RAM contents (no forwarding).

FSM:
- IDLE: clr_start=1 -> DRAIN, clr_busy=1 next cycle.
- DRAIN: no new pushes; when the FIFO is empty -> CLEAR, clear address=0.
- CLEAR: each writer grant writes CLEAR_CHAR at the clear address and increments it. A grant at address CLEAR_WORDS-1 -> IDLE, with clr_busy=0 the following cycle.
- clr_start while clr_busy=1 is ignored.

Test Plan:
- Reset then idle: rd_valid=0, cpu_wr_ready=1, mem_we=0; rd_req=1, rd_addr=5 with RAM[5]=8'h41 -> rd_data=8'h41, rd_valid=1 exactly 2 cycles later.
- CPU writes (10,'A'),(11,'B') with rd_req=0 -> mem_we pulses on consecutive cycles in order; a subsequent read of 11 returns 8'h42.
- FIFO full: 5 back-to-back writes with rd_req held 1, STARVE_LIMIT=0 -> cpu_wr_ready drops after the 4th; nothing written until rd_req=0, then all 4 drain in order and the 5th is accepted.
- Starvation: STARVE_LIMIT=3, rd_req held 1, one pending write -> write granted on the 4th waiting cycle; rd_valid=0 for that slot only; counter restarts.
- Clear: clr_start with 2 FIFO entries, rd_req=0 -> both entries written first, then addresses 0..2399 written with 8'h20; clr_busy high throughout and low after the last write; cpu_wr_ready=0 during the sweep.
- Reset mid-clear at address 1000 -> clr_busy=0 the next cycle; no further writes; clr_start restarts the sweep from address 0.
